if_fetch_ctrl: RTL



---
 rtl/if_fetch_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches words over req/ready and
// buffers one instruction across decode stalls. Option macro: IFETCH_MISALIGN_TRAP_EN.
module if_fetch_ctrl #(
    parameter int                       PC_DATA_WIDTH     = 20,
    parameter int                       INSTRUCTION_WIDTH = 32,
    parameter logic [PC_DATA_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_DATA_WIDTH-1:0]     branch_target,
    output logic                         inst_mem_req,
    output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr,
    input  logic                         inst_mem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] inst_out,
    output logic [PC_DATA_WIDTH-1:0]     pc_out,
    output logic                         inst_valid,
    output logic                         misalign_err,
    output logic [1:0]                   state_dbg
);

    // Handshake: a word transfer completes on any rising edge where
    // inst_mem_req=1 and inst_mem_ready=1; inst_mem_addr is held while req=1 and
    // ready=0, and req may drop without completion only on reset.

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PC_DATA_WIDTH-1:0] PC_STEP     = PC_DATA_WIDTH'(4);
    localparam logic [PC_DATA_WIDTH-1:0] RESET_PC_AL = {RESET_PC[PC_DATA_WIDTH-1:2], 2'b00};

    state_t                         state, state_nxt;
    logic [PC_DATA_WIDTH-1:0]       pc_reg, pc_nxt;
    logic [PC_DATA_WIDTH-1:0]       redirect_pc, redirect_nxt;
    logic                           discard_pending, discard_nxt;
    logic [INSTRUCTION_WIDTH-1:0]   hold_inst, hold_inst_nxt;
    logic [PC_DATA_WIDTH-1:0]       hold_pc, hold_pc_nxt;
    logic [INSTRUCTION_WIDTH-1:0]   inst_nxt;
    logic [PC_DATA_WIDTH-1:0]       pc_out_nxt;
    logic                           valid_nxt;
    logic [PC_DATA_WIDTH-1:0]       target_al;
    logic [PC_DATA_WIDTH-1:0]       pc_inc;

    assign target_al     = {branch_target[PC_DATA_WIDTH-1:2], 2'b00};
    assign pc_inc        = pc_reg + PC_STEP;
    assign inst_mem_req  = (state == FETCH);
    assign inst_mem_addr = pc_reg;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BOOT;
            pc_reg          <= RESET_PC_AL;
            redirect_pc     <= '0;
            discard_pending <= 1'b0;
            hold_inst       <= '0;
            hold_pc         <= '0;
            inst_out        <= '0;
            pc_out          <= '0;
            inst_valid      <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc_reg          <= pc_nxt;
            redirect_pc     <= redirect_nxt;
            discard_pending <= discard_nxt;
            hold_inst       <= hold_inst_nxt;
            hold_pc         <= hold_pc_nxt;
            inst_out        <= inst_nxt;
            pc_out          <= pc_out_nxt;
            inst_valid      <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_reg;
        redirect_nxt  = redirect_pc;
        discard_nxt   = discard_pending;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        inst_nxt      = inst_out;
        pc_out_nxt    = pc_out;
        valid_nxt     = inst_valid;

        // Outputs only move when decode is not stalled; redirect state always moves.
        case (state)
            BOOT: begin
                state_nxt = FETCH;
                if (branch_taken) begin
                    pc_nxt = target_al;
                    if (!stall) begin
                        inst_nxt  = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (branch_taken) begin
                    if (inst_mem_ready) begin
                        pc_nxt      = target_al;
                        discard_nxt = 1'b0;
                    end else begin
                        // Request in flight: address must stay put until it completes.
                        redirect_nxt = target_al;
                        discard_nxt  = 1'b1;
                    end
                    if (!stall) begin
                        inst_nxt  = '0;
                        valid_nxt = 1'b0;
                    end
                end else if (inst_mem_ready) begin
                    if (discard_pending) begin
                        pc_nxt      = redirect_pc;
                        discard_nxt = 1'b0;
                        if (!stall) begin
                            inst_nxt  = '0;
                            valid_nxt = 1'b0;
                        end
                    end else if (!stall) begin
                        inst_nxt   = inst_mem_data_in;
                        pc_out_nxt = pc_inc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc_inc;
                    end else begin
                        hold_inst_nxt = inst_mem_data_in;
                        hold_pc_nxt   = pc_inc;
                        pc_nxt        = pc_inc;
                        state_nxt     = HOLD;
                    end
                end else if (!stall) begin
                    inst_nxt  = '0;
                    valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_nxt    = target_al;
                    state_nxt = FETCH;
                    if (!stall) begin
                        inst_nxt  = '0;
                        valid_nxt = 1'b0;
                    end
                end else if (!stall) begin
                    inst_nxt   = hold_inst;
                    pc_out_nxt = hold_pc;
                    valid_nxt  = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign misalign_err = err_q;
`else
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];
    assign misalign_err       = 1'b0;
`endif

endmodule
